// File: rtl/fifo_param_pkg.sv
// rtl/fifo_param_pkg.sv - shared FIFO widths and skid-buffer types
package fifo_param_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int SKID_DEPTH = 2;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
  typedef logic [1:0]            skid_occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - 2-entry skid buffer with same-cycle push+pop
//
// Ports:
//   CLK, nRST  clock, asynchronous active-low reset
//   push       write push_data at the tail this cycle
//   push_data  word to write
//   pop        remove the head this cycle (caller guarantees occ != 0)
//   occ        current occupancy 0..2
//   head       buf0, the oldest entry
module fifo_skid_buf
  import fifo_param_pkg::*;
#(
  parameter int DATA_W = FIFO_WIDTH
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output skid_occ_t         occ,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] buf0, buf1;
  logic [DATA_W-1:0] buf0_next, buf1_next;
  skid_occ_t         occ_after_pop, occ_next;

  always_comb begin
    occ_after_pop = occ - skid_occ_t'(pop);
    occ_next      = occ_after_pop + skid_occ_t'(push);
    buf0_next     = buf0;
    buf1_next     = buf1;
    if (pop) buf0_next = buf1;
    // The tail is judged after the pop has shifted, so a push that
    // coincides with a pop lands directly behind the new head.
    if (push) begin
      if (occ_after_pop == '0) buf0_next = push_data;
      else                     buf1_next = push_data;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      occ  <= '0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      occ  <= occ_next;
      buf0 <= buf0_next;
      buf1 <= buf1_next;
    end
  end

  assign head = buf0;

endmodule

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - drains FIFO read side into a valid/ready stream
//
// Ports:
//   CLK, nRST     clock, asynchronous active-low reset
//   en            drain enable; low blocks new FIFO reads
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data, one cycle after fifo_rd_en
//   fifo_rd_err   FIFO read error, aligned with fifo_rd_data
//   fifo_rd_en    FIFO pop request
//   out_valid     out_data holds a word
//   out_ready     sink accepts out_data
//   out_data      head of the skid buffer
//   word_cnt      delivered words, saturating
//   err_cnt       errored read responses, saturating
//   busy          words buffered or a read in flight
module fifo_rd_drain
  import fifo_param_pkg::*;
#(
  parameter int DATA_W = FIFO_WIDTH,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_err,
  output logic              fifo_rd_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  skid_occ_t  occ;
  logic       inflight;
  logic       pop;
  logic       push;
  logic       ret_err;
  logic [2:0] fill;

  assign pop     = out_valid && out_ready;
  assign push    = inflight && !fifo_rd_err;
  assign ret_err = inflight && fifo_rd_err;

  // Slots already committed: stored words plus the one still returning.
  assign fill = {1'b0, occ} + {2'b00, inflight};

  // A pop this cycle frees a slot in time for the response two edges out,
  // which is what keeps full rate under a ready sink. Gated by nRST so no
  // pop request escapes while the block is held in reset.
  assign fifo_rd_en = nRST && en && !fifo_empty &&
                      ((fill < 3'(SKID_DEPTH)) || pop);

  fifo_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .occ       (occ),
    .head      (out_data)
  );

  assign out_valid = (occ != '0);
  assign busy      = (occ != '0) || inflight;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      inflight <= 1'b0;
      word_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop && (word_cnt != '1))     word_cnt <= word_cnt + 1'b1;
      if (ret_err && (err_cnt != '1))  err_cnt  <= err_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      assert (fill <= 3'(SKID_DEPTH))
        else $fatal(1, "fifo_rd_drain: occ + inflight exceeds skid depth");
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - directed table-driven bench for fifo_rd_drain
module tb_fifo_rd_drain;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_err;
  logic       fifo_rd_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] word_cnt;
  logic [3:0] err_cnt;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fifo_rd_drain #(.DATA_W(8), .CNT_W(4)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_err  (fifo_rd_err),
    .fifo_rd_en   (fifo_rd_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .word_cnt     (word_cnt),
    .err_cnt      (err_cnt),
    .busy         (busy)
  );

  // FIFO model: contents written by the stimulus, read pointer advanced here.
  logic [7:0] mem [64];
  bit         err_mem [64];
  int         wr_ptr = 0;
  int         rd_ptr;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr       <= 0;
      fifo_rd_err  <= 1'b0;
      fifo_rd_data <= 8'h00;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      fifo_rd_err  <= err_mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end else begin
      fifo_rd_err  <= 1'b0;
    end
  end

  // Monitor, sampled mid-cycle while inputs are stable.
  logic [7:0] rx [$];
  int         rd_cnt  = 0;
  bit         saw_bad = 0;

  always @(negedge CLK) begin
    if (nRST && out_valid && out_ready) rx.push_back(out_data);
    if (nRST && fifo_rd_en) rd_cnt++;
    if (nRST && out_valid && out_data == 8'hB3) saw_bad = 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Holds reset, loads n words base+i (error on err_idx), releases just after an edge.
  task automatic load_and_reset(input int n, input logic [7:0] base, input int err_idx);
    nRST = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = base + 8'(i);
      err_mem[i] = (i == err_idx);
    end
    wr_ptr = n;
    step(2);
    nRST = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic       rdy;
    logic       exp_rd_en;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [3:0] exp_wcnt;
    logic       exp_busy;
  } vec_t;

  vec_t vt [16];

  initial begin
    int base;

    // Streaming with 5-cycle back-pressure window, cycle by cycle.
    vt[0]  = '{1, 1, 1, 0, 8'h00, 4'd0, 0};
    vt[1]  = '{1, 1, 1, 0, 8'h00, 4'd0, 1};
    vt[2]  = '{1, 1, 1, 1, 8'hA1, 4'd0, 1};
    vt[3]  = '{1, 0, 0, 1, 8'hA2, 4'd1, 1};
    vt[4]  = '{1, 0, 0, 1, 8'hA2, 4'd1, 1};
    vt[5]  = '{1, 0, 0, 1, 8'hA2, 4'd1, 1};
    vt[6]  = '{1, 0, 0, 1, 8'hA2, 4'd1, 1};
    vt[7]  = '{1, 0, 0, 1, 8'hA2, 4'd1, 1};
    vt[8]  = '{1, 1, 1, 1, 8'hA2, 4'd1, 1};
    vt[9]  = '{1, 1, 1, 1, 8'hA3, 4'd2, 1};
    vt[10] = '{1, 1, 1, 1, 8'hA4, 4'd3, 1};
    vt[11] = '{1, 1, 1, 1, 8'hA5, 4'd4, 1};
    vt[12] = '{1, 1, 1, 1, 8'hA6, 4'd5, 1};
    vt[13] = '{1, 1, 0, 1, 8'hA7, 4'd6, 1};
    vt[14] = '{1, 1, 0, 1, 8'hA8, 4'd7, 1};
    vt[15] = '{1, 1, 0, 0, 8'h00, 4'd8, 0};

    nRST      = 1'b0;
    en        = 1'b1;
    out_ready = 1'b0;

    // Reset hold with a non-empty FIFO and en=1.
    nRST = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 8'hA1 + 8'(i);
      err_mem[i] = 1'b0;
    end
    wr_ptr = 8;
    @(negedge CLK);
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_wcnt", word_cnt, 0);
    chk("reset_ecnt", err_cnt, 0);
    chk("reset_busy", busy, 0);
    step(1);
    nRST = 1'b1;

    for (int r = 0; r < 16; r++) begin
      en        = vt[r].en;
      out_ready = vt[r].rdy;
      @(negedge CLK);
      chk($sformatf("row%0d_rd_en", r), fifo_rd_en, vt[r].exp_rd_en);
      chk($sformatf("row%0d_valid", r), out_valid, vt[r].exp_valid);
      if (vt[r].exp_valid) chk($sformatf("row%0d_data", r), out_data, vt[r].exp_data);
      chk($sformatf("row%0d_wcnt", r), word_cnt, vt[r].exp_wcnt);
      chk($sformatf("row%0d_busy", r), busy, vt[r].exp_busy);
      step(1);
    end

    // Read error on the 3rd of 5 reads.
    en = 1'b1;
    out_ready = 1'b1;
    load_and_reset(5, 8'hB1, 2);
    base = rx.size();
    step(12);
    chk("err_delivered", rx.size() - base, 4);
    if (rx.size() - base == 4) begin
      chk("err_w0", rx[base],   8'hB1);
      chk("err_w1", rx[base+1], 8'hB2);
      chk("err_w2", rx[base+2], 8'hB4);
      chk("err_w3", rx[base+3], 8'hB5);
    end
    chk("err_ecnt", err_cnt, 1);
    chk("err_wcnt", word_cnt, 4);
    chk("err_b3_never_shown", saw_bad, 0);

    // Enable dropped one cycle after the first request.
    en = 1'b1;
    out_ready = 1'b1;
    base = rx.size();
    load_and_reset(3, 8'hC1, -1);
    base = rd_cnt;
    step(1);
    en = 1'b0;
    step(6);
    chk("en_rd_pulses", rd_cnt - base, 1);
    chk("en_wcnt", word_cnt, 1);
    chk("en_last_word", rx[rx.size()-1], 8'hC1);
    chk("en_busy", busy, 0);
    chk("en_valid", out_valid, 0);

    // Saturation of word_cnt at 15, then asynchronous reset with occ=2.
    en = 1'b1;
    out_ready = 1'b1;
    load_and_reset(20, 8'h10, 5);
    base = rx.size();
    step(30);
    chk("sat_delivered", rx.size() - base, 19);
    chk("sat_wcnt", word_cnt, 15);
    chk("sat_ecnt", err_cnt, 1);
    for (int i = 20; i < 24; i++) begin
      mem[i]     = 8'h60 + 8'(i - 20);
      err_mem[i] = 1'b0;
    end
    out_ready = 1'b0;
    wr_ptr = 24;
    step(4);
    @(negedge CLK);
    chk("full_valid", out_valid, 1);
    chk("full_rd_en", fifo_rd_en, 0);
    chk("full_data", out_data, 8'h60);
    chk("full_wcnt", word_cnt, 15);
    nRST = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_wcnt", word_cnt, 0);
    chk("arst_ecnt", err_cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", fifo_rd_en, 0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
